tick_timer: RTL and testbench

TICK_TIMER -- requirements
Module: tick_timer

---
 rtl/tick_timer.sv | 179 +++++++++++++++++
 tb/tb_tick_timer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/tick_timer.sv
// Tick timer: derives a tick from a selectable bit of a free-running divider,
// counts ticks up to a captured period and raises a request on each expiry.
// Supports one-shot and auto-reload operation with sticky overrun and error flags.
module tick_timer #(
  parameter int NSize  = 3,
  parameter int NCount = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NSize-1:0]  div,
  input  logic [2:0]        tapSel,
  input  logic [NCount-1:0] period,
  input  logic              periodic,
  input  logic              start,
  input  logic              stop,
  input  logic              ack,
  output logic              tick,
  output logic              req,
  output logic              busy,
  output logic              overrun,
  output logic              err
);

  typedef enum logic [1:0] {
    Idle = 2'd0,
    Run  = 2'd1,
    Fire = 2'd2
  } stateT;

  logic [NSize-1:0]  div_q, divPrev_q;
  logic [2:0]        tap_q, tapPrev_q;
  logic [1:0]        prime_q;
  logic              tick_q;

  stateT             state_q, state_d;
  logic [NCount-1:0] count_q, count_d;
  logic [NCount-1:0] period_q, period_d;
  logic              periodic_q, periodic_d;
  logic              req_q, req_d;
  logic              overrun_q, overrun_d;
  logic              err_q, err_d;

  int                tapIdx;
  logic              curBit, prevBit;
  logic              edgeSeen;
  logic [NCount-1:0] countInc;
  logic              expiry;

  // Pick the selected bit from both the current and previous div samples using one tap value.
  always_comb begin
    tapIdx  = (int'(tap_q) >= NSize) ? NSize - 1 : int'(tap_q);
    curBit  = 1'b0;
    prevBit = 1'b0;
    for (int i = 0; i < NSize; i++) begin
      if (i == tapIdx) begin
        curBit  = div_q[i];
        prevBit = divPrev_q[i];
      end
    end
  end

  // A rising edge only counts once two real samples exist and the tap did not just move.
  assign edgeSeen = (prime_q == 2'd2) && (tap_q == tapPrev_q) && !prevBit && curBit;

  // Sample the divider and tap each cycle and register the edge detection as the tick pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q     <= '0;
      divPrev_q <= '0;
      tap_q     <= '0;
      tapPrev_q <= '0;
      prime_q   <= '0;
      tick_q    <= 1'b0;
    end else begin
      div_q     <= div;
      divPrev_q <= div_q;
      tap_q     <= tapSel;
      tapPrev_q <= tap_q;
      if (prime_q != 2'd2) prime_q <= prime_q + 2'd1;
      tick_q    <= edgeSeen;
    end
  end

  assign countInc = count_q + 1'b1;
  assign expiry   = tick_q && (countInc == period_q);

  // Controller state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= Idle;
      count_q    <= '0;
      period_q   <= '0;
      periodic_q <= 1'b0;
      req_q      <= 1'b0;
      overrun_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      period_q   <= period_d;
      periodic_q <= periodic_d;
      req_q      <= req_d;
      overrun_q  <= overrun_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic: stop wins, then start from Idle, then tick counting and acknowledge handling.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    period_d   = period_q;
    periodic_d = periodic_q;
    req_d      = req_q;
    overrun_d  = overrun_q;
    err_d      = err_q;
    if (stop) begin
      state_d = Idle;
      req_d   = 1'b0;
      count_d = '0;
    end else begin
      case (state_q)
        Idle: begin
          if (start) begin
            if (period == '0) begin
              err_d = 1'b1;
            end else begin
              state_d    = Run;
              count_d    = '0;
              period_d   = period;
              periodic_d = periodic;
              overrun_d  = 1'b0;
              err_d      = 1'b0;
            end
          end
        end
        Run: begin
          if (expiry) begin
            state_d = Fire;
            req_d   = 1'b1;
            count_d = '0;
          end else if (tick_q) begin
            count_d = countInc;
          end
        end
        Fire: begin
          if (periodic_q) begin
            if (expiry) begin
              count_d = '0;
              if (!ack) overrun_d = 1'b1;
            end else begin
              if (tick_q) count_d = countInc;
              if (ack) begin
                req_d   = 1'b0;
                state_d = Run;
              end
            end
          end else if (ack) begin
            req_d   = 1'b0;
            state_d = Idle;
            count_d = '0;
          end
        end
        default: begin
          state_d = Idle;
          req_d   = 1'b0;
          count_d = '0;
        end
      endcase
    end
  end

  assign tick    = tick_q;
  assign req     = req_q;
  assign busy    = (state_q != Idle);
  assign overrun = overrun_q;
  assign err     = err_q;

endmodule

// File: tb/tb_tick_timer.sv
// Testbench for tick_timer: directed scenarios plus randomized traffic, all
// compared each cycle against a behavioural model of the timer.
module tb_tick_timer;

  localparam int NSize  = 3;
  localparam int NCount = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic [NSize-1:0]  div;
  logic [2:0]        tapSel;
  logic [NCount-1:0] period;
  logic              periodic, start, stop, ack;
  logic              tick, req, busy, overrun, err;

  int checks = 0;
  int passes = 0;
  int divCnt = 0;
  bit holdDiv = 1'b0;
  int curTap = 0;
  int tickCount;

  // model: sample history and timer behaviour
  int divHist[$];
  int tapHist[$];
  bit mTick, mReq, mBusy, mOverrun, mErr, mPeriodic;
  int mCount, mPeriod;

  tick_timer #(.NSize(NSize), .NCount(NCount)) dut (
    .clock(clock), .reset(reset), .div(div), .tapSel(tapSel),
    .period(period), .periodic(periodic), .start(start), .stop(stop),
    .ack(ack), .tick(tick), .req(req), .busy(busy),
    .overrun(overrun), .err(err)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs == exp) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
  endtask

  function automatic void modelReset();
    divHist.delete();
    tapHist.delete();
    mTick = 0; mReq = 0; mBusy = 0; mOverrun = 0; mErr = 0; mPeriodic = 0;
    mCount = 0; mPeriod = 0;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  function automatic void modelEdge();
    int n, idx, prevB, curB;
    bit nextTick, hit;
    if (stop) begin
      mBusy = 0; mReq = 0; mCount = 0;
    end else if (!mBusy) begin
      if (start) begin
        if (period == 0) mErr = 1;
        else begin
          mBusy = 1; mCount = 0; mPeriod = int'(period); mPeriodic = periodic;
          mOverrun = 0; mErr = 0;
        end
      end
    end else if (mReq && !mPeriodic) begin
      if (ack) begin mReq = 0; mBusy = 0; end
    end else begin
      hit = mTick && (mCount + 1 == mPeriod);
      if (hit) begin
        if (mReq && !ack) mOverrun = 1;
        mReq = 1; mCount = 0;
      end else begin
        if (mTick) mCount++;
        if (ack) mReq = 0;
      end
    end
    nextTick = 0;
    n = divHist.size();
    if (n >= 2 && tapHist[n-1] == tapHist[n-2]) begin
      idx   = (tapHist[n-1] >= NSize) ? NSize - 1 : tapHist[n-1];
      prevB = (divHist[n-2] >> idx) & 1;
      curB  = (divHist[n-1] >> idx) & 1;
      nextTick = (prevB == 0) && (curB == 1);
    end
    divHist.push_back(int'(div));
    tapHist.push_back(int'(tapSel));
    if (divHist.size() > 2) begin
      void'(divHist.pop_front());
      void'(tapHist.pop_front());
    end
    mTick = nextTick;
  endfunction

  task automatic checkAll(input string where);
    checkOutput({where, ".tick"},    int'(tick),    int'(mTick));
    checkOutput({where, ".req"},     int'(req),     int'(mReq));
    checkOutput({where, ".busy"},    int'(busy),    int'(mBusy));
    checkOutput({where, ".overrun"}, int'(overrun), int'(mOverrun));
    checkOutput({where, ".err"},     int'(err),     int'(mErr));
  endtask

  // Drive one cycle of inputs, step the model, then compare after the edge.
  task automatic applyStimulus(input bit st, input bit sp, input bit ak,
                               input int per, input bit perd, input int tap);
    start    = st;
    stop     = sp;
    ack      = ak;
    period   = NCount'(per);
    periodic = perd;
    tapSel   = 3'(tap);
    div      = NSize'(divCnt);
    if (!holdDiv) divCnt++;
    modelEdge();
    @(posedge clock);
    #1;
    checkAll("cyc");
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, curTap);
  endtask

  initial begin
    reset = 1'b1; div = '0; tapSel = '0; period = '0;
    periodic = 0; start = 0; stop = 0; ack = 0;
    modelReset();
    #12;
    checkAll("reset");
    reset = 1'b0;

    // tick rate on bit 1, then on clamped tap 7 (bit 2)
    curTap = 1;
    idleCycles(8);
    tickCount = 0;
    for (int i = 0; i < 32; i++) begin
      applyStimulus(0, 0, 0, 0, 0, curTap);
      if (tick) tickCount++;
    end
    checkOutput("tap1_rate", tickCount, 8);
    curTap = 7;
    idleCycles(16);
    tickCount = 0;
    for (int i = 0; i < 32; i++) begin
      applyStimulus(0, 0, 0, 0, 0, curTap);
      if (tick) tickCount++;
    end
    checkOutput("tap7_rate", tickCount, 4);

    // one-shot, period 3 on bit 0
    curTap = 0;
    idleCycles(4);
    applyStimulus(1, 0, 0, 3, 0, curTap);
    for (int i = 0; i < 50 && !req; i++) applyStimulus(0, 0, 0, 0, 0, curTap);
    checkOutput("oneshot_req", int'(req), 1);
    idleCycles(3);
    applyStimulus(0, 0, 1, 0, 0, curTap);
    checkOutput("oneshot_done_busy", int'(busy), 0);
    checkOutput("oneshot_done_req", int'(req), 0);

    // periodic period 2, no ack -> overrun
    applyStimulus(1, 0, 0, 2, 1, curTap);
    idleCycles(20);
    checkOutput("periodic_overrun", int'(overrun), 1);
    checkOutput("periodic_req_held", int'(req), 1);
    applyStimulus(0, 0, 1, 0, 0, curTap);
    idleCycles(1);
    checkOutput("periodic_busy_after_ack", int'(busy), 1);
    idleCycles(6);

    // zero period error, then cleared by a valid start
    applyStimulus(0, 1, 0, 0, 0, curTap);
    applyStimulus(1, 0, 0, 0, 0, curTap);
    checkOutput("zero_period_err", int'(err), 1);
    checkOutput("zero_period_busy", int'(busy), 0);
    applyStimulus(1, 0, 0, 5, 1, curTap);
    checkOutput("valid_start_err", int'(err), 0);
    checkOutput("valid_start_busy", int'(busy), 1);

    // asynchronous reset while running with count 2
    for (int i = 0; i < 40 && mCount != 2; i++) applyStimulus(0, 0, 0, 0, 0, curTap);
    checkOutput("reached_count2", mCount, 2);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_rst.tick", int'(tick), 0);
    checkOutput("async_rst.req", int'(req), 0);
    checkOutput("async_rst.busy", int'(busy), 0);
    checkOutput("async_rst.overrun", int'(overrun), 0);
    checkOutput("async_rst.err", int'(err), 0);
    modelReset();
    #3;
    reset = 1'b0;

    // stop with simultaneous ack while firing
    applyStimulus(1, 0, 0, 1, 0, curTap);
    for (int i = 0; i < 20 && !req; i++) applyStimulus(0, 0, 0, 0, 0, curTap);
    checkOutput("fire_before_stop", int'(req), 1);
    applyStimulus(1, 1, 1, 4, 1, curTap);
    checkOutput("stop_ack_req", int'(req), 0);
    checkOutput("stop_ack_busy", int'(busy), 0);

    // maximum period reaches expiry without wrapping
    applyStimulus(1, 0, 0, 255, 0, curTap);
    for (int i = 0; i < 600 && !req; i++) applyStimulus(0, 0, 0, 0, 0, curTap);
    checkOutput("max_period_req", int'(req), 1);
    applyStimulus(0, 0, 1, 0, 0, curTap);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 24) == 0) curTap = $urandom_range(0, 7);
      holdDiv = ($urandom_range(0, 7) == 0);
      applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 59) == 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 5),
                    1'($urandom_range(0, 1)), curTap);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
